sumador_serie_ctrl: RTL and testbench

Bit-serial N-bit adder controller. Accepts two N-bit operands on a start pulse and feeds one bit pair per clock, LSB first, through a full-adder cell. The cell is built from two instances of the team's 1-bit half-adder `summed` (xi, yi -> Si, Co) plus an OR gate. The block sequences the shift, carry and count logic and returns the N-bit sum and carry-out with a start/busy/done handshake. It is the sequential follow-on to the half-adder and full-adder combinational practice blocks.

---
 rtl/sumador_serie_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_sumador_serie_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/sumador_serie_ctrl.sv
// -----------------------------------------------------------------------------
// sumador_serie_ctrl -- bit-serial N-bit adder controller.
//
// Two N-bit operands are captured on a start request and added one bit pair
// per clock, LSB first, through a full-adder cell made of two `summed`
// half-adders plus an OR for the carry. After N RUN cycles the sum and final
// carry are registered on s/co and a one-cycle done pulse is raised.
//
// Ports:
//   clk    in   1  system clock, rising edge active
//   rst_n  in   1  asynchronous active-low reset
//   start  in   1  operation request, sampled only while idle
//   a, b   in   N  operands, captured on the accepting edge
//   s      out  N  registered sum, held until the next completion
//   co     out  1  registered final carry-out, same validity as s
//   busy   out  1  high while an operation is in progress (RUN and DONE)
//   done   out  1  single-cycle completion pulse
// -----------------------------------------------------------------------------

// 1-bit half-adder: sum and carry of two input bits.
module summed (
    input  logic xi,
    input  logic yi,
    output logic Si,
    output logic Co
);
    assign Si = xi ^ yi;
    assign Co = xi & yi;
endmodule

module sumador_serie_ctrl #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] s,
    output logic         co,
    output logic         busy,
    output logic         done
);

    // Counter must hold N-1; keep at least one bit so N=1 still elaborates.
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST_COUNT = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_r;
    state_t          state_s;
    logic [N-1:0]    ra_r;
    logic [N-1:0]    rb_r;
    logic [N-1:0]    acc_r;
    logic            c_r;
    logic [CW-1:0]   count_r;

    logic [N-1:0]    ra_s;
    logic [N-1:0]    rb_s;
    logic [N-1:0]    acc_s;
    logic            c_s;
    logic [CW-1:0]   count_s;
    logic [N-1:0]    s_s;
    logic            co_s;
    logic            busy_s;
    logic            done_s;

    logic            p_s;
    logic            g1_s;
    logic            sum_bit_s;
    logic            g2_s;
    logic            carry_s;
    logic [N-1:0]    acc_shift_s;

    // Full-adder cell: first half-adder on the operand LSBs, second folds in the carry.
    summed u_ha1 (
        .xi (ra_r[0]),
        .yi (rb_r[0]),
        .Si (p_s),
        .Co (g1_s)
    );

    summed u_ha2 (
        .xi (p_s),
        .yi (c_r),
        .Si (sum_bit_s),
        .Co (g2_s)
    );

    assign carry_s = g1_s | g2_s;

    // New sum bit enters at the MSB so after N shifts bit 0 holds the first sum bit.
    assign acc_shift_s = (acc_r >> 1) | (N'(sum_bit_s) << (N - 1));

    // Next-state and next-datapath values; every register holds unless its state acts on it.
    always_comb begin
        state_s = state_r;
        ra_s    = ra_r;
        rb_s    = rb_r;
        acc_s   = acc_r;
        c_s     = c_r;
        count_s = count_r;
        s_s     = s;
        co_s    = co;

        case (state_r)
            IDLE: begin
                if (start) begin
                    ra_s    = a;
                    rb_s    = b;
                    acc_s   = {N{1'b0}};
                    c_s     = 1'b0;
                    count_s = {CW{1'b0}};
                    state_s = RUN;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                c_s   = carry_s;
                acc_s = acc_shift_s;
                ra_s  = ra_r >> 1;
                rb_s  = rb_r >> 1;
                if (count_r == LAST_COUNT) begin
                    // Last bit pair: publish the result including this cycle's bit.
                    // Count is left at N-1 so it never wraps.
                    count_s = count_r;
                    s_s     = acc_shift_s;
                    co_s    = carry_s;
                    state_s = DONE;
                end else begin
                    count_s = count_r + CW'(1);
                    state_s = RUN;
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase

        busy_s = (state_s != IDLE);
        done_s = (state_s == DONE);
    end

    // State, datapath and registered outputs, asynchronously cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            ra_r    <= {N{1'b0}};
            rb_r    <= {N{1'b0}};
            acc_r   <= {N{1'b0}};
            c_r     <= 1'b0;
            count_r <= {CW{1'b0}};
            s       <= {N{1'b0}};
            co      <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_r <= state_s;
            ra_r    <= ra_s;
            rb_r    <= rb_s;
            acc_r   <= acc_s;
            c_r     <= c_s;
            count_r <= count_s;
            s       <= s_s;
            co      <= co_s;
            busy    <= busy_s;
            done    <= done_s;
        end
    end

endmodule

// File: tb/tb_sumador_serie_ctrl.sv
// Scoreboard bench for sumador_serie_ctrl: an N=8 and an N=4 instance.
module tb_sumador_serie_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       start8, busy8, done8, co8;
    logic [7:0] a8, b8, s8;
    logic       start4, busy4, done4, co4;
    logic [3:0] a4, b4, s4;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int last4    = -1;

    logic [8:0] q8[$];
    logic [4:0] q4[$];

    sumador_serie_ctrl #(.N(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
        .s(s8), .co(co8), .busy(busy8), .done(done8)
    );

    sumador_serie_ctrl #(.N(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4),
        .s(s4), .co(co4), .busy(busy4), .done(done4)
    );

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Monitor for the N=8 instance: every done pulse must match the oldest expectation.
    always @(negedge clk) begin : mon8
        logic [8:0] exp8;
        if (done8 === 1'b1) begin
            checks++;
            if (q8.size() == 0) begin
                failures++;
                $display("FAIL done8_unexpected got={co,s}=%h exp=no_done", {co8, s8});
            end else begin
                exp8 = q8.pop_front();
                if ({co8, s8} !== exp8) begin
                    failures++;
                    $display("FAIL sum8 got=%h exp=%h", {co8, s8}, exp8);
                end
            end
        end
    end

    // Monitor for the N=4 instance: result check plus done-to-done spacing.
    always @(negedge clk) begin : mon4
        logic [4:0] exp4;
        if (done4 === 1'b1) begin
            checks++;
            if (q4.size() == 0) begin
                failures++;
                $display("FAIL done4_unexpected got={co,s}=%h exp=no_done", {co4, s4});
            end else begin
                exp4 = q4.pop_front();
                if ({co4, s4} !== exp4) begin
                    failures++;
                    $display("FAIL sum4 got=%h exp=%h", {co4, s4}, exp4);
                end
            end
            if (last4 >= 0) begin
                checks++;
                if (cyc - last4 != 6) begin
                    failures++;
                    $display("FAIL done4_spacing got=%0d exp=6", cyc - last4);
                end
            end
            last4 = cyc;
        end
    end

    // Issue one N=8 operation; returns 1 time unit after the accepting edge.
    task automatic issue8(input logic [7:0] x, input logic [7:0] y);
        a8 = x;
        b8 = y;
        start8 = 1'b1;
        q8.push_back({1'b0, x} + {1'b0, y});
        @(posedge clk);
        #1 start8 = 1'b0;
    endtask

    task automatic drain8(input int maxc);
        int n = 0;
        while (q8.size() != 0 && n < maxc) begin
            @(posedge clk);
            n++;
        end
        chk("drain8_timeout", q8.size(), 32'd0);
    endtask

    task automatic drain4(input int maxc);
        int n = 0;
        while (q4.size() != 0 && n < maxc) begin
            @(posedge clk);
            n++;
        end
        chk("drain4_timeout", q4.size(), 32'd0);
    endtask

    initial begin
        rst_n  = 1'b0;
        start8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
        start4 = 1'b0; a4 = 4'h0;  b4 = 4'h0;

        // 1: reset
        repeat (3) @(posedge clk);
        #1;
        chk("rst_s", {24'd0, s8}, 32'd0);
        chk("rst_co_busy_done", {co8, busy8, done8}, 32'd0);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("idle_s_co", {23'd0, co8, s8}, 32'd0);
        chk("idle_busy_done", {busy8, done8, busy4, done4}, 32'd0);

        // 2: 05 + 03 with timing
        issue8(8'h05, 8'h03);
        chk("t2_busy_k", busy8, 32'd1);
        chk("t2_done_k", done8, 32'd0);
        repeat (7) @(posedge clk);
        #1;
        chk("t2_done_k7", done8, 32'd0);
        chk("t2_busy_k7", busy8, 32'd1);
        @(posedge clk);
        #1;
        chk("t2_done_k8", done8, 32'd1);
        chk("t2_busy_k8", busy8, 32'd1);
        @(posedge clk);
        #1;
        chk("t2_done_k9", done8, 32'd0);
        chk("t2_busy_k9", busy8, 32'd0);
        chk("t2_s_hold", {24'd0, s8}, 32'h08);
        drain8(5);

        // 3: full carry ripple
        repeat (2) @(posedge clk);
        #1;
        issue8(8'hFF, 8'h01);
        drain8(20);
        repeat (3) @(posedge clk);
        #1;

        // 4: start held high, operands changed mid-RUN
        a8 = 8'hFF; b8 = 8'hFF; start8 = 1'b1;
        q8.push_back(9'h1FE);
        q8.push_back(9'h000);
        repeat (5) @(posedge clk);
        #1 begin a8 = 8'h00; b8 = 8'h00; end
        repeat (15) @(posedge clk);
        #1 start8 = 1'b0;
        drain8(20);
        repeat (3) @(posedge clk);
        #1;
        chk("t4_idle", {busy8, done8}, 32'd0);

        // 5: asynchronous reset during the 4th RUN cycle
        issue8(8'hAA, 8'h55);
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("t5_rst_s", {24'd0, s8}, 32'd0);
        chk("t5_rst_co", co8, 32'd0);
        chk("t5_rst_busy_done", {busy8, done8}, 32'd0);
        void'(q8.pop_back());
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("t5_idle_after", {busy8, done8}, 32'd0);
        issue8(8'h01, 8'h01);
        drain8(20);
        repeat (2) @(posedge clk);
        #1;

        // 6: N=4 exhaustive, back-to-back
        for (int i = 0; i < 256; i++) begin
            a4 = i[7:4];
            b4 = i[3:0];
            q4.push_back({1'b0, a4} + {1'b0, b4});
            start4 = 1'b1;
            repeat (6) @(posedge clk);
            #1;
        end
        start4 = 1'b0;
        drain4(30);
        repeat (4) @(posedge clk);
        #1;
        chk("t6_idle", {busy4, done4}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
